// File: rtl/llr_calc_param.sv
// LLR calculator: per-subcarrier kf scaling of demapper metrics, optional merging of the two
// repetition halves of a block, then shift/saturate to the decoder input format.
// "do" is a reserved word in SystemVerilog, so the LLR output port is do_llr.
module llr_calc_param #(
    parameter int KF_W    = 12,
    parameter int MI_W    = 15,
    parameter int N_SC    = 480,
    parameter int BLK_LEN = 17280,
    parameter int SHIFT   = 5,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_combine,
    input  logic [KF_W-1:0]  di_kf,
    input  logic             di_kf_vld,
    input  logic [MI_W-1:0]  di_mi,
    input  logic             di_mi_vld,
    input  logic             di_sof,
    output logic [OUT_W-1:0] do_llr,
    output logic             do_vld,
    output logic             do_last,
    output logic             err_sync
);

    localparam int PW  = KF_W + MI_W;
    localparam int CW  = PW + 1;
    localparam int H   = BLK_LEN / 2;
    localparam int KAW = (N_SC > 1) ? $clog2(N_SC) : 1;
    localparam int BW  = (BLK_LEN > 2) ? $clog2(BLK_LEN) : 1;
    localparam int HAW = (H > 1) ? $clog2(H) : 1;

    localparam logic [KAW-1:0]       KF_LAST  = KAW'(N_SC - 1);
    localparam logic [BW-1:0]        BLK_LAST = BW'(BLK_LEN - 1);
    localparam logic [BW-1:0]        HALF     = BW'(H);
    localparam logic signed [CW-1:0] SAT_MAX  = CW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN  = -SAT_MAX;

    // Strobes are plain valid qualifiers with no ready: a sample is consumed on every
    // cycle its *_vld is high, and do_vld marks each cycle do_llr/do_last carry a result.

    logic [KF_W-1:0] kf_ram [N_SC];
    logic [PW-1:0]   hbuf [H];

    logic [KAW-1:0] kf_wr_addr, kf_rd_addr, rd_addr;
    logic [BW-1:0]  blk_cnt, idx;
    logic           in_blk, comb_q, mode, sof_v, take;

    logic            s1_vld, s1_comb;
    logic [BW-1:0]   s1_idx;
    logic [KF_W-1:0] s1_kf;
    logic [MI_W-1:0] s1_mi;

    logic                 s2_vld, s2_comb, s2_second;
    logic [BW-1:0]        s2_idx;
    logic signed [PW-1:0] s2_p;
    logic [HAW-1:0]       hb_addr;

    logic          s3_vld, s3_comb, s3_last;
    logic [PW-1:0] s3_pa, s3_pb;

    logic signed [CW-1:0] pa_x, pb_x, c, s;
    logic [CW-1:0]        mag_a, mag_b;
    logic [OUT_W-1:0]     sat;

    always_comb begin
        sof_v   = di_sof & di_mi_vld;
        rd_addr = sof_v ? '0 : kf_rd_addr;
        idx     = sof_v ? '0 : blk_cnt;
        mode    = sof_v ? cfg_combine : comb_q;
        // Samples outside a block (after reset or after the last index) are dropped.
        take    = di_mi_vld & (sof_v | in_blk);
    end

    always_comb begin
        s2_second = (s2_idx >= HALF);
        hb_addr   = s2_second ? HAW'(s2_idx - HALF) : HAW'(s2_idx);
    end

    // Read-first kf table: a same-cycle write at the read address returns the old entry.
    always_ff @(posedge clk) begin
        if (di_kf_vld) begin
            kf_ram[kf_wr_addr] <= di_kf;
        end
        s1_kf <= kf_ram[rd_addr];
    end

    // First-half products are stored; second-half samples fetch their partner one stage later.
    always_ff @(posedge clk) begin
        if (s2_vld && s2_comb && !s2_second) begin
            hbuf[hb_addr] <= s2_p;
        end
        s3_pa <= hbuf[hb_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kf_wr_addr <= '0;
            kf_rd_addr <= '0;
            blk_cnt    <= '0;
            in_blk     <= 1'b0;
            comb_q     <= 1'b0;
            err_sync   <= 1'b0;
            s1_vld     <= 1'b0;
            s1_comb    <= 1'b0;
            s1_idx     <= '0;
            s1_mi      <= '0;
            s2_vld     <= 1'b0;
            s2_comb    <= 1'b0;
            s2_idx     <= '0;
            s2_p       <= '0;
            s3_vld     <= 1'b0;
            s3_comb    <= 1'b0;
            s3_last    <= 1'b0;
            s3_pb      <= '0;
            do_llr     <= '0;
            do_vld     <= 1'b0;
            do_last    <= 1'b0;
        end else begin
            if (di_kf_vld) begin
                kf_wr_addr <= (kf_wr_addr == KF_LAST) ? '0 : kf_wr_addr + KAW'(1);
            end
            if (di_mi_vld) begin
                kf_rd_addr <= (rd_addr == KF_LAST) ? '0 : rd_addr + KAW'(1);
            end
            if (sof_v) begin
                comb_q <= cfg_combine;
                if (blk_cnt != '0) begin
                    err_sync <= 1'b1;
                end
            end
            if (take) begin
                blk_cnt <= (idx == BLK_LAST) ? '0 : idx + BW'(1);
                in_blk  <= (idx != BLK_LAST);
            end

            s1_vld  <= take;
            s1_comb <= mode;
            s1_idx  <= idx;
            s1_mi   <= di_mi;

            s2_vld  <= s1_vld;
            s2_comb <= s1_comb;
            s2_idx  <= s1_idx;
            s2_p    <= $signed({{MI_W{s1_kf[KF_W-1]}}, s1_kf})
                     * $signed({{KF_W{s1_mi[MI_W-1]}}, s1_mi});

            s3_vld  <= s2_vld && (!s2_comb || s2_second);
            s3_comb <= s2_comb;
            s3_last <= (s2_idx == BLK_LAST);
            s3_pb   <= s2_p;

            do_vld  <= s3_vld;
            do_last <= s3_vld && s3_last;
            if (s3_vld) begin
                do_llr <= sat;
            end
        end
    end

    // Combine rule: agreeing signs add; disagreeing signs keep the stronger one, ties go to Pb.
    always_comb begin
        pa_x  = {s3_pa[PW-1], s3_pa};
        pb_x  = {s3_pb[PW-1], s3_pb};
        mag_a = pa_x[CW-1] ? -pa_x : pa_x;
        mag_b = pb_x[CW-1] ? -pb_x : pb_x;
        if (!s3_comb) begin
            c = pb_x;
        end else if (pa_x[CW-1] == pb_x[CW-1]) begin
            c = pa_x + pb_x;
        end else if (mag_a > mag_b) begin
            c = pa_x;
        end else begin
            c = pb_x;
        end
        s = c >>> SHIFT;
        if (s > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (s < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = s[OUT_W-1:0];
        end
    end

endmodule
